wts_slot_master: RTL



---
 rtl/wts_slot_master.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wts_slot_master.sv
// MSX slot-bus initiator: turns req/ack transactions into /SLTSL,/MERQ,/RD,/WR
// memory cycles with programmable setup/strobe/hold timing and /WAIT extension.
module wts_slot_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 6,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        int_req,
    output logic        slot_nreset,
    output logic [15:0] slot_a,
    inout  wire  [7:0]  slot_d,
    output logic        slot_nsltsl,
    output logic        slot_nmerq,
    output logic        slot_nrd,
    output logic        slot_nwr,
    input  logic        slot_nwait,
    input  logic        slot_nint
);
    // state  | meaning
    // IDLE   | bus released, waiting for req
    // SETUP  | select and address valid, strobe not yet asserted
    // STROBE | /RD or /WR low, extended while synchronised /WAIT is low
    // HOLD   | strobe released, select and write data still held
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam int MAX_C = (SETUP_CYCLES > STROBE_CYCLES)
                         ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                         : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int CNT_W = $clog2(MAX_C + 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic [7:0]       wdata_q;
    logic             oe;
    logic             wait_m, wait_s;
    logic             int_m;

    assign slot_d = oe ? wdata_q : 8'hzz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_m  <= 1'b1;
            wait_s  <= 1'b1;
            int_m   <= 1'b0;
            int_req <= 1'b0;
        end else begin
            wait_m  <= slot_nwait;
            wait_s  <= wait_m;
            int_m   <= ~slot_nint;
            int_req <= int_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= 8'h00;
            oe          <= 1'b0;
            busy        <= 1'b0;
            ack         <= 1'b0;
            rdata       <= 8'h00;
            slot_nreset <= 1'b0;
            slot_a      <= 16'h0000;
            slot_nsltsl <= 1'b1;
            slot_nmerq  <= 1'b1;
            slot_nrd    <= 1'b1;
            slot_nwr    <= 1'b1;
        end else begin
            slot_nreset <= 1'b1;
            ack         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        wr_q        <= wr;
                        wdata_q     <= wdata;
                        slot_a      <= addr;
                        slot_nsltsl <= 1'b0;
                        slot_nmerq  <= 1'b0;
                        busy        <= 1'b1;
                        oe          <= wr;
                        cnt         <= CNT_W'(SETUP_CYCLES - 1);
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        slot_nrd <= wr_q;
                        slot_nwr <= ~wr_q;
                        cnt      <= CNT_W'(STROBE_CYCLES - 1);
                        state    <= S_STROBE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (wait_s) begin
                        slot_nrd <= 1'b1;
                        slot_nwr <= 1'b1;
                        if (!wr_q) rdata <= slot_d;
                        cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        state <= S_HOLD;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        slot_nsltsl <= 1'b1;
                        slot_nmerq  <= 1'b1;
                        oe          <= 1'b0;
                        busy        <= 1'b0;
                        ack         <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
